// File: rtl/book_cmd_dispatcher.sv
// Feeds decoded market commands from a FIFO to the bid/ask order books,
// one start pulse per issue, honouring each book's busy handshake.
module book_cmd_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int ID_W    = 16,
    parameter int PRICE_W = 16,
    parameter int QTY_W   = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_opcode,
    input  logic                    in_side,
    input  logic [ID_W-1:0]         in_order_id,
    input  logic [PRICE_W-1:0]      in_price,
    input  logic [QTY_W-1:0]        in_quantity,
    output logic                    bid_start_book,
    output logic                    ask_start_book,
    output logic [2:0]              bid_request,
    output logic [2:0]              ask_request,
    output logic [ID_W-1:0]         bid_order_id,
    output logic [ID_W-1:0]         ask_order_id,
    output logic [PRICE_W-1:0]      bid_price,
    output logic [PRICE_W-1:0]      ask_price,
    output logic [QTY_W-1:0]        bid_quantity,
    output logic [QTY_W-1:0]        ask_quantity,
    input  logic                    bid_busy,
    input  logic                    ask_busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [15:0]             drop_count,
    output logic                    idle
);

    // Opcode codes shared with the order_book constants.
    localparam logic [2:0] ADD_ORDER     = 3'd1;
    localparam logic [2:0] CANCEL_ORDER  = 3'd2;
    localparam logic [2:0] EXECUTE_ORDER = 3'd3;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [2:0]         op;
        logic               side;
        logic [ID_W-1:0]    id;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } entry_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic [PW-1:0]   count_d;
    state_t          state_q;
    state_t          state_d;
    logic            push;
    logic            pop;
    logic            drop;
    logic            issue_bid;
    logic            issue_ask;
    logic            head_legal;

    assign count      = wr_ptr - rd_ptr;
    assign in_ready   = count < PW'(DEPTH);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr[AW-1:0]];
    assign head_legal = head.op inside {ADD_ORDER, CANCEL_ORDER, EXECUTE_ORDER};
    assign fifo_count = count;
    assign idle       = (count == '0) && !bid_start_book && !ask_start_book
                        && !bid_busy && !ask_busy;

    // A side's own start still being high blocks it for the cycle before
    // the book can raise busy; a stalled head blocks the other side too.
    always_comb begin
        state_d   = state_q;
        drop      = 1'b0;
        issue_bid = 1'b0;
        issue_ask = 1'b0;
        unique case (state_q)
            IDLE: ;
            ISSUE: begin
                if (!head_legal)
                    drop = 1'b1;
                else if (!head.side && !bid_busy && !bid_start_book)
                    issue_bid = 1'b1;
                else if (head.side && !ask_busy && !ask_start_book)
                    issue_ask = 1'b1;
            end
            default: ;
        endcase
        pop     = drop || issue_bid || issue_ask;
        count_d = count + PW'(push) - PW'(pop);
        state_d = (count_d != '0) ? ISSUE : IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{op: in_opcode, side: in_side, id: in_order_id,
                                     price: in_price, qty: in_quantity};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            state_q        <= IDLE;
            drop_count     <= '0;
            bid_start_book <= 1'b0;
            ask_start_book <= 1'b0;
            bid_request    <= '0;
            ask_request    <= '0;
            bid_order_id   <= '0;
            ask_order_id   <= '0;
            bid_price      <= '0;
            ask_price      <= '0;
            bid_quantity   <= '0;
            ask_quantity   <= '0;
        end else begin
            state_q        <= state_d;
            bid_start_book <= issue_bid;
            ask_start_book <= issue_ask;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (drop && drop_count != '1)
                drop_count <= drop_count + 16'd1;
            if (issue_bid) begin
                bid_request  <= head.op;
                bid_order_id <= head.id;
                bid_price    <= head.price;
                bid_quantity <= head.qty;
            end
            if (issue_ask) begin
                ask_request  <= head.op;
                ask_order_id <= head.id;
                ask_price    <= head.price;
                ask_quantity <= head.qty;
            end
        end
    end

endmodule

// File: tb/tb_book_cmd_dispatcher.sv
// Scoreboard bench: issued commands are predicted in FIFO order and checked
// whenever a start pulse appears; simple book models drive the busy inputs.
module tb_book_cmd_dispatcher;

    localparam logic [2:0] ADD_ORDER     = 3'd1;
    localparam logic [2:0] CANCEL_ORDER  = 3'd2;
    localparam logic [2:0] EXECUTE_ORDER = 3'd3;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = '0;
    logic        in_side = 1'b0;
    logic [15:0] in_order_id = '0, in_price = '0, in_quantity = '0;
    logic        bid_start_book, ask_start_book;
    logic [2:0]  bid_request, ask_request;
    logic [15:0] bid_order_id, ask_order_id, bid_price, ask_price, bid_quantity, ask_quantity;
    logic        bid_busy = 1'b0, ask_busy = 1'b0;
    logic [3:0]  fifo_count;
    logic [15:0] drop_count;
    logic        idle;

    book_cmd_dispatcher #(.DEPTH(8), .ID_W(16), .PRICE_W(16), .QTY_W(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_side(in_side), .in_order_id(in_order_id),
        .in_price(in_price), .in_quantity(in_quantity),
        .bid_start_book(bid_start_book), .ask_start_book(ask_start_book),
        .bid_request(bid_request), .ask_request(ask_request),
        .bid_order_id(bid_order_id), .ask_order_id(ask_order_id),
        .bid_price(bid_price), .ask_price(ask_price),
        .bid_quantity(bid_quantity), .ask_quantity(ask_quantity),
        .bid_busy(bid_busy), .ask_busy(ask_busy),
        .fifo_count(fifo_count), .drop_count(drop_count), .idle(idle)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        side;
        logic [2:0]  op;
        logic [15:0] id;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;

    cmd_t        exp_q[$];
    int          bid_cyc_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic [15:0] model_drops = '0;
    logic        bid_force = 1'b0, ask_force = 1'b0;
    logic        rand_hold = 1'b0;
    int          bid_cnt = 0, ask_cnt = 0;

    always @(posedge clk_in) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int hold_len();
        return rand_hold ? int'($urandom_range(1, 4)) : 4;
    endfunction

    // Book model: busy rises one edge after it samples start, then holds.
    initial begin
        logic sb, sa;
        forever begin
            @(negedge clk_in);
            sb = bid_start_book;
            sa = ask_start_book;
            @(posedge clk_in);
            #1;
            if (rst_in) begin
                bid_cnt = 0;
                ask_cnt = 0;
            end else begin
                if (sb) bid_cnt = hold_len(); else if (bid_cnt > 0) bid_cnt--;
                if (sa) ask_cnt = hold_len(); else if (ask_cnt > 0) ask_cnt--;
            end
            bid_busy = bid_force || (bid_cnt > 0);
            ask_busy = ask_force || (ask_cnt > 0);
        end
    end

    task automatic check_issue(input logic side, input logic [2:0] op, input logic [15:0] id,
                               input logic [15:0] price, input logic [15:0] qty,
                               input logic prev_start, input logic prev_busy);
        cmd_t e;
        check(side ? "ask_spacing" : "bid_spacing", {prev_start, prev_busy}, 2'b00);
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_start: side %0d issued with nothing expected (cycle %0d)", side, cyc);
        end else begin
            e = exp_q.pop_front();
            check("issue_side", side, e.side);
            check(side ? "ask_payload" : "bid_payload", {op, id, price, qty},
                  {e.op, e.id, e.price, e.qty});
        end
    endtask

    // Monitor: pops and compares on every start pulse.
    initial begin
        logic pbs = 0, pbb = 0, pas = 0, pab = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (bid_start_book && ask_start_book)
                    check("dual_start", 2'b11, 2'b01);
                if (bid_start_book) begin
                    bid_cyc_q.push_back(cyc);
                    check_issue(1'b0, bid_request, bid_order_id, bid_price, bid_quantity, pbs, pbb);
                end
                if (ask_start_book)
                    check_issue(1'b1, ask_request, ask_order_id, ask_price, ask_quantity, pas, pab);
            end
            pbs = bid_start_book; pbb = bid_busy;
            pas = ask_start_book; pab = ask_busy;
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic side, input logic [15:0] id,
                            input logic [15:0] price, input logic [15:0] qty);
        int unsigned waited = 0;
        @(negedge clk_in);
        in_valid = 1'b1; in_opcode = op; in_side = side;
        in_order_id = id; in_price = price; in_quantity = qty;
        while (!in_ready && waited < 2000) begin
            @(negedge clk_in);
            waited++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: in_ready stuck at 0 (cycle %0d)", cyc);
        end else if (op inside {ADD_ORDER, CANCEL_ORDER, EXECUTE_ORDER}) begin
            exp_q.push_back('{side: side, op: op, id: id, price: price, qty: qty});
        end else if (model_drops != 16'hFFFF) begin
            model_drops++;
        end
        @(posedge clk_in);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        @(negedge clk_in);
        while (n < 3000 && !(exp_q.size() == 0 && fifo_count == 0 && !bid_busy && !ask_busy
                             && !bid_start_book && !ask_start_book)) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 3000) begin
            compared++;
            mismatched++;
            $display("FAIL %s_drain: timeout, %0d expected left, fifo_count %0d", tag, exp_q.size(), fifo_count);
        end else begin
            check({tag, "_idle"}, idle, 1'b1);
            check({tag, "_drops"}, drop_count, model_drops);
        end
    endtask

    function automatic logic [2:0] rand_op();
        int unsigned r = $urandom_range(0, 11);
        logic [2:0] ill [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        if (r < 3) return ill[$urandom_range(0, 4)];
        return 3'(r % 3 + 1);
    endfunction

    initial begin
        logic [127:0] outs;
        int g;

        repeat (3) @(negedge clk_in);
        check("reset_outputs", {bid_start_book, ask_start_book, bid_request, ask_request,
              bid_order_id, ask_order_id, bid_price, ask_price, bid_quantity, ask_quantity,
              fifo_count, drop_count}, '0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("reset_ready", {in_ready, fifo_count, idle}, {1'b1, 4'd0, 1'b1});

        // Single add: start high exactly during cycle 1-2.
        push_cmd(ADD_ORDER, 1'b0, 16'd5, 16'd100, 16'd10);
        @(negedge clk_in);
        check("add_start_c0", bid_start_book, 1'b0);
        @(negedge clk_in);
        check("add_start_c1", {bid_start_book, ask_start_book}, 2'b10);
        @(negedge clk_in);
        check("add_start_c2", bid_start_book, 1'b0);
        repeat (3) @(negedge clk_in);
        check("add_held", {bid_request, bid_price, bid_quantity, ask_start_book},
              {ADD_ORDER, 16'd100, 16'd10, 1'b0});
        wait_idle("single_add");

        // Busy lag: second start only after busy (4 cycles) falls.
        bid_cyc_q.delete();
        push_cmd(ADD_ORDER, 1'b0, 16'd20, 16'd200, 16'd1);
        push_cmd(ADD_ORDER, 1'b0, 16'd21, 16'd201, 16'd2);
        wait_idle("busy_lag");
        if (bid_cyc_q.size() == 2)
            check("busy_lag_gap", bid_cyc_q[1] - bid_cyc_q[0], 6);
        else
            check("busy_lag_starts", bid_cyc_q.size(), 2);

        // Head-of-line blocking.
        bid_force = 1'b1;
        repeat (2) @(negedge clk_in);
        push_cmd(CANCEL_ORDER, 1'b0, 16'd7, 16'd0, 16'd3);
        push_cmd(ADD_ORDER, 1'b1, 16'd9, 16'd55, 16'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("hol_no_ask", ask_start_book, 1'b0);
        end
        bid_force = 1'b0;
        wait_idle("hol");

        // Full FIFO.
        bid_force = 1'b1;
        ask_force = 1'b1;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 8; i++)
            push_cmd(3'($urandom_range(1, 3)), 1'($urandom), 16'(100 + i), 16'($urandom), 16'($urandom));
        @(negedge clk_in);
        check("full_state", {in_ready, fifo_count}, {1'b0, 4'd8});
        in_valid = 1'b1; in_opcode = ADD_ORDER; in_side = 1'b0; in_order_id = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            check("full_no_accept", in_ready, 1'b0);
            @(negedge clk_in);
        end
        in_valid = 1'b0;
        bid_force = 1'b0;
        ask_force = 1'b0;
        wait_idle("full");

        // Illegal opcode between two legal commands.
        check("drops_before", drop_count, 16'd0);
        push_cmd(ADD_ORDER, 1'b1, 16'd30, 16'd300, 16'd3);
        push_cmd(3'b111, 1'b0, 16'd31, 16'd301, 16'd3);
        push_cmd(EXECUTE_ORDER, 1'b0, 16'd32, 16'd302, 16'd3);
        wait_idle("illegal");
        check("drops_after", drop_count, 16'd1);

        // Asynchronous reset with ask start high and three queued.
        bid_force = 1'b1;
        ask_force = 1'b1;
        repeat (2) @(negedge clk_in);
        push_cmd(ADD_ORDER, 1'b1, 16'd40, 16'd400, 16'd4);
        for (int i = 0; i < 3; i++)
            push_cmd(CANCEL_ORDER, 1'b0, 16'(41 + i), 16'd0, 16'd1);
        ask_force = 1'b0;
        g = 0;
        @(negedge clk_in);
        while (!ask_start_book && g < 20) begin
            @(negedge clk_in);
            g++;
        end
        check("rst_setup", {ask_start_book, fifo_count}, {1'b1, 4'd3});
        #2;
        rst_in = 1'b1;
        #1;
        outs = {bid_start_book, ask_start_book, bid_request, ask_request, bid_order_id,
                ask_order_id, bid_price, ask_price, bid_quantity, ask_quantity,
                fifo_count, drop_count};
        check("async_reset_outputs", outs, '0);
        exp_q.delete();
        model_drops = '0;
        bid_force = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_reset", {fifo_count, in_ready}, {4'd0, 1'b1});
        wait_idle("reset");

        // Randomized traffic with random book hold times.
        rand_hold = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push_cmd(rand_op(), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
        end
        wait_idle("random");

        // Saturation of the drop counter.
        for (int i = 0; i < 65536; i++)
            push_cmd(3'b111, 1'b0, 16'(i), 16'd0, 16'd0);
        wait_idle("saturate");
        check("drop_saturated", drop_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
